// File: rtl/usb_host_txn_engine.sv
// Host-side USB transaction sequencer: runs OUT and IN transactions, tracks the
// DATA0/DATA1 toggle and retries on NAK, timeout or bad/duplicate data.
module usb_host_txn_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_NAK        = 8,
  parameter int unsigned MAX_TIMEOUT    = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dir_in,
  input  logic       toggle_clr,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       success,
  output logic       failure,
  output logic [1:0] fail_code,
  output logic       toggle,
  input  logic       sent,
  output logic       send_token,
  output logic       token_in,
  output logic       send_data,
  output logic       data_pid1,
  output logic       send_ack,
  input  logic       rec_start,
  input  logic       rec_ACK,
  input  logic       rec_NAK,
  input  logic       rec_data_ok,
  input  logic       rec_data_pid1,
  input  logic       rec_data_bad
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned NW = $clog2(MAX_NAK + 1);
  localparam int unsigned OW = $clog2(MAX_TIMEOUT + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NW-1:0] NAK_LIMIT  = NW'(MAX_NAK);
  localparam logic [OW-1:0] TO_LIMIT   = OW'(MAX_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_DATA_TX,
    S_WAIT_HS,
    S_WAIT_DATA,
    S_ACK_TX
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NW-1:0] nak_q, nak_d, nak_inc;
  logic [OW-1:0] to_q, to_d, to_inc;
  logic          toggle_q, toggle_d;
  logic          dir_q, dir_d;
  logic          ack_good_q, ack_good_d;
  logic          busy_q;
  logic          timeout_hit;

  // Saturating increments so the counters never wrap.
  assign nak_inc = (nak_q == '1) ? nak_q : nak_q + NW'(1);
  assign to_inc  = (to_q == '1) ? to_q : to_q + OW'(1);

  // A receiver that is mid-packet suppresses the timeout.
  assign timeout_hit = (timer_q == TIMER_LAST) && !rec_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      nak_q      <= '0;
      to_q       <= '0;
      toggle_q   <= 1'b0;
      dir_q      <= 1'b0;
      ack_good_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      nak_q      <= nak_d;
      to_q       <= to_d;
      toggle_q   <= toggle_d;
      dir_q      <= dir_d;
      ack_good_q <= ack_good_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    nak_d      = nak_q;
    to_d       = to_q;
    toggle_d   = toggle_q;
    dir_d      = dir_q;
    ack_good_d = ack_good_q;
    done       = 1'b0;
    success    = 1'b0;
    failure    = 1'b0;
    fail_code  = 2'd0;
    send_token = 1'b0;
    token_in   = 1'b0;
    send_data  = 1'b0;
    data_pid1  = 1'b0;
    send_ack   = 1'b0;

    if (state_q == S_WAIT_HS || state_q == S_WAIT_DATA) begin
      if (rec_start) begin
        timer_d = '0;
      end else if (timer_q != TIMER_LAST) begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (state_q != S_IDLE && abort) begin
      done      = 1'b1;
      failure   = 1'b1;
      fail_code = 2'd3;
      state_d   = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (toggle_clr) toggle_d = 1'b0;
          if (start) begin
            send_token = 1'b1;
            token_in   = dir_in;
            dir_d      = dir_in;
            nak_d      = '0;
            to_d       = '0;
            state_d    = S_TOKEN;
          end
        end

        S_TOKEN: begin
          if (sent) begin
            if (!dir_q) begin
              send_data = 1'b1;
              data_pid1 = toggle_q;
              state_d   = S_DATA_TX;
            end else begin
              timer_d = '0;
              state_d = S_WAIT_DATA;
            end
          end
        end

        S_DATA_TX: begin
          if (sent) begin
            timer_d = '0;
            state_d = S_WAIT_HS;
          end
        end

        // OUT handshake wait: retries resend only the DATA packet.
        S_WAIT_HS: begin
          if (rec_ACK) begin
            done     = 1'b1;
            success  = 1'b1;
            toggle_d = !toggle_q;
            state_d  = S_IDLE;
          end else if (rec_NAK) begin
            nak_d = nak_inc;
            if (nak_inc == NAK_LIMIT) begin
              done      = 1'b1;
              failure   = 1'b1;
              fail_code = 2'd1;
              state_d   = S_IDLE;
            end else begin
              send_data = 1'b1;
              data_pid1 = toggle_q;
              state_d   = S_DATA_TX;
            end
          end else if (timeout_hit) begin
            to_d = to_inc;
            if (to_inc == TO_LIMIT) begin
              done      = 1'b1;
              failure   = 1'b1;
              fail_code = 2'd2;
              state_d   = S_IDLE;
            end else begin
              send_data = 1'b1;
              data_pid1 = toggle_q;
              state_d   = S_DATA_TX;
            end
          end
        end

        // IN data wait: retries resend the IN token.
        S_WAIT_DATA: begin
          if (rec_data_ok) begin
            send_ack   = 1'b1;
            ack_good_d = (rec_data_pid1 == toggle_q);
            state_d    = S_ACK_TX;
          end else if (rec_NAK) begin
            nak_d = nak_inc;
            if (nak_inc == NAK_LIMIT) begin
              done      = 1'b1;
              failure   = 1'b1;
              fail_code = 2'd1;
              state_d   = S_IDLE;
            end else begin
              send_token = 1'b1;
              token_in   = 1'b1;
              state_d    = S_TOKEN;
            end
          end else if (rec_data_bad || timeout_hit) begin
            to_d = to_inc;
            if (to_inc == TO_LIMIT) begin
              done      = 1'b1;
              failure   = 1'b1;
              fail_code = 2'd2;
              state_d   = S_IDLE;
            end else begin
              send_token = 1'b1;
              token_in   = 1'b1;
              state_d    = S_TOKEN;
            end
          end
        end

        // A duplicate DATA was ACKed to resync the device but counts as a retry.
        S_ACK_TX: begin
          if (sent) begin
            if (ack_good_q) begin
              done     = 1'b1;
              success  = 1'b1;
              toggle_d = !toggle_q;
              state_d  = S_IDLE;
            end else begin
              to_d = to_inc;
              if (to_inc == TO_LIMIT) begin
                done      = 1'b1;
                failure   = 1'b1;
                fail_code = 2'd2;
                state_d   = S_IDLE;
              end else begin
                send_token = 1'b1;
                token_in   = 1'b1;
                state_d    = S_TOKEN;
              end
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign toggle = toggle_q;

endmodule

// File: tb/tb_usb_host_txn_engine.sv
// Scoreboard bench for usb_host_txn_engine: stimulus queues the expected output
// events, a negedge monitor pops and compares whenever the DUT emits one.
module tb_usb_host_txn_engine;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, dir_in, toggle_clr, abort, sent;
  logic       rec_start, rec_ACK, rec_NAK, rec_data_ok, rec_data_pid1, rec_data_bad;
  logic       busy, done, success, failure, toggle;
  logic [1:0] fail_code;
  logic       send_token, token_in, send_data, data_pid1, send_ack;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  usb_host_txn_engine #(
    .TIMEOUT_CYCLES(16),
    .MAX_NAK       (8),
    .MAX_TIMEOUT   (3)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .dir_in       (dir_in),
    .toggle_clr   (toggle_clr),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .success      (success),
    .failure      (failure),
    .fail_code    (fail_code),
    .toggle       (toggle),
    .sent         (sent),
    .send_token   (send_token),
    .token_in     (token_in),
    .send_data    (send_data),
    .data_pid1    (data_pid1),
    .send_ack     (send_ack),
    .rec_start    (rec_start),
    .rec_ACK      (rec_ACK),
    .rec_NAK      (rec_NAK),
    .rec_data_ok  (rec_data_ok),
    .rec_data_pid1(rec_data_pid1),
    .rec_data_bad (rec_data_bad)
  );

  always #5 clock = ~clock;

  // Event word: {send_token, token_in, send_data, data_pid1, send_ack, done, success, failure, fail_code}
  function automatic logic [9:0] ev_tok(input logic in_pid);
    return {1'b1, in_pid, 8'b0};
  endfunction
  function automatic logic [9:0] ev_data(input logic p);
    return {2'b0, 1'b1, p, 6'b0};
  endfunction
  function automatic logic [9:0] ev_ack();
    return {4'b0, 1'b1, 5'b0};
  endfunction
  function automatic logic [9:0] ev_ok();
    return {5'b0, 3'b110, 2'd0};
  endfunction
  function automatic logic [9:0] ev_fail(input logic [1:0] c);
    return {5'b0, 3'b101, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [9:0] ev;
    ev = {send_token, token_in, send_data, data_pid1, send_ack, done, success, failure, fail_code};
    if (reset_n && (send_token || send_data || send_ack || done)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event act=%03h exp=none t=%0t", ev, $time);
      end else begin
        chk("event", 32'(ev), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic do_start(input logic d, input logic clr);
    exp_q.push_back(ev_tok(d));
    start = 1'b1; dir_in = d; toggle_clr = clr;
    step();
    start = 1'b0; dir_in = 1'b0; toggle_clr = 1'b0;
  endtask
  task automatic p_sent();
    sent = 1'b1; step(); sent = 1'b0;
  endtask
  task automatic p_ack();
    rec_ACK = 1'b1; step(); rec_ACK = 1'b0;
  endtask
  task automatic p_nak();
    rec_NAK = 1'b1; step(); rec_NAK = 1'b0;
  endtask
  task automatic p_data(input logic pid);
    rec_data_ok = 1'b1; rec_data_pid1 = pid; step(); rec_data_ok = 1'b0; rec_data_pid1 = 1'b0;
  endtask
  task automatic p_bad();
    rec_data_bad = 1'b1; step(); rec_data_bad = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    {start, dir_in, toggle_clr, abort, sent} = '0;
    {rec_start, rec_ACK, rec_NAK, rec_data_ok, rec_data_pid1, rec_data_bad} = '0;
    idle(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_toggle", 32'(toggle), 0);
    chk("rst_outs", 32'({done, send_token, send_data, send_ack}), 0);
    reset_n = 1'b1;
    idle(2);

    // OUT, DATA0, ACK after 10 idle cycles
    do_start(1'b0, 1'b0);
    chk("busy_after_start", 32'(busy), 1);
    idle(2);
    exp_q.push_back(ev_data(1'b0)); p_sent();
    idle(2); p_sent();
    idle(10);
    exp_q.push_back(ev_ok()); p_ack();
    chk("out1_busy", 32'(busy), 0);
    chk("out1_toggle", 32'(toggle), 1);
    idle(2);

    // OUT, DATA1, 7 NAKs then ACK
    do_start(1'b0, 1'b0);
    exp_q.push_back(ev_data(1'b1)); p_sent();
    p_sent();
    for (int i = 0; i < 7; i++) begin
      idle(2);
      exp_q.push_back(ev_data(1'b1)); p_nak();
      p_sent();
    end
    idle(1);
    exp_q.push_back(ev_ok()); p_ack();
    chk("nak7_toggle", 32'(toggle), 0);
    idle(2);

    // OUT, 8 NAKs ends in failure code 1 with no further DATA
    do_start(1'b0, 1'b0);
    exp_q.push_back(ev_data(1'b0)); p_sent();
    p_sent();
    for (int i = 0; i < 7; i++) begin
      idle(1);
      exp_q.push_back(ev_data(1'b0)); p_nak();
      p_sent();
    end
    idle(1);
    exp_q.push_back(ev_fail(2'd1)); p_nak();
    idle(3);
    chk("nak8_busy", 32'(busy), 0);
    chk("nak8_toggle", 32'(toggle), 0);

    // IN, no reply: three 16-cycle waits, second stretched by rec_start
    do_start(1'b1, 1'b0);
    p_sent();
    idle(14);
    chk("to1_early", 32'(send_token), 0);
    exp_q.push_back(ev_tok(1'b1)); step();
    chk("to1_edge", 32'(send_token), 1);
    step();
    p_sent();
    idle(9);
    rec_start = 1'b1; step(); rec_start = 1'b0;
    idle(14);
    chk("to2_early", 32'(send_token), 0);
    exp_q.push_back(ev_tok(1'b1)); step();
    chk("to2_edge", 32'(send_token), 1);
    step();
    p_sent();
    exp_q.push_back(ev_fail(2'd2));
    idle(15);
    chk("to3_done", 32'(done), 1);
    idle(2);
    chk("to3_toggle", 32'(toggle), 0);

    // IN, bad DATA (no ACK, token resent) then good DATA0
    do_start(1'b1, 1'b0);
    p_sent();
    idle(3);
    exp_q.push_back(ev_tok(1'b1)); p_bad();
    p_sent();
    idle(2);
    exp_q.push_back(ev_ack()); p_data(1'b0);
    exp_q.push_back(ev_ok()); p_sent();
    chk("bad_then_good_toggle", 32'(toggle), 1);
    idle(2);

    // IN with toggle=1: stray ACK ignored, duplicate DATA0, then DATA1
    do_start(1'b1, 1'b0);
    p_sent();
    idle(2); p_ack(); idle(1);
    exp_q.push_back(ev_ack()); p_data(1'b0);
    exp_q.push_back(ev_tok(1'b1)); p_sent();
    chk("dup_toggle", 32'(toggle), 1);
    p_sent();
    idle(1);
    exp_q.push_back(ev_ack()); p_data(1'b1);
    exp_q.push_back(ev_ok()); p_sent();
    chk("dup_final_toggle", 32'(toggle), 0);
    idle(2);

    // Abort in DATA_TX, late sent ignored, then a normal OUT
    do_start(1'b0, 1'b0);
    exp_q.push_back(ev_data(1'b0)); p_sent();
    exp_q.push_back(ev_fail(2'd3));
    abort = 1'b1; step(); abort = 1'b0;
    p_sent();
    idle(2);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_toggle", 32'(toggle), 0);
    do_start(1'b0, 1'b0);
    exp_q.push_back(ev_data(1'b0)); p_sent();
    p_sent(); idle(3);
    exp_q.push_back(ev_ok()); p_ack();
    chk("post_abort_toggle", 32'(toggle), 1);
    idle(2);

    // toggle_clr with start: DATA0 must be accepted as good
    do_start(1'b1, 1'b1);
    chk("clr_toggle", 32'(toggle), 0);
    p_sent(); idle(1);
    exp_q.push_back(ev_ack()); p_data(1'b0);
    exp_q.push_back(ev_ok()); p_sent();
    chk("clr_final_toggle", 32'(toggle), 1);
    idle(2);

    // Reset mid-transaction: back to idle with no done
    do_start(1'b0, 1'b0);
    idle(1);
    reset_n = 1'b0;
    idle(2);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_toggle", 32'(toggle), 0);
    reset_n = 1'b1;
    idle(4);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_host_txn_engine.md
Name: usb_host_txn_engine

Overview:
Parametrised host-side USB transaction sequencer. It runs both OUT (token, DATA, wait handshake) and IN (token, wait DATA, send ACK) transactions, keeps track of the DATA0/DATA1 toggle, and retries on NAK or timeout up to configurable limits. It sits between the read/write FSM and the packet sender/receiver pair, and replaces the fixed OUT-only sequencer.

Parameters:
TIMEOUT_CYCLES, 256, idle cycles after our last packet before a timeout retry (min 2)
MAX_NAK, 8, NAKs that end the transaction as a failure (min 1)
MAX_TIMEOUT, 8, timeouts/bad-DATA events that end the transaction as a failure (min 1)

Ports:
clock  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
start  in  1  pulse; begin a transaction; ignored unless idle
dir_in  in  1  sampled with start: 1=IN, 0=OUT
toggle_clr  in  1  force toggle to DATA0; honoured only when idle
abort  in  1  pulse; terminate the current transaction
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at the end of a transaction
success  out  1  with done: transaction completed
failure  out  1  with done: transaction failed
fail_code  out  2  valid with done&failure: 1=NAK limit, 2=timeout limit, 3=abort
toggle  out  1  current data toggle (0=DATA0)
sent  in  1  sender finished the current packet (1-cycle pulse)
send_token  out  1  1-cycle pulse: send a token
token_in  out  1  with send_token: 1=IN PID, 0=OUT PID
send_data  out  1  1-cycle pulse: send a DATA packet
data_pid1  out  1  with send_data: 1=DATA1, 0=DATA0
send_ack  out  1  1-cycle pulse: send an ACK handshake
rec_start  in  1  receiver detected start of a packet
rec_ACK  in  1  ACK received (pulse)
rec_NAK  in  1  NAK received (pulse)
rec_data_ok  in  1  DATA packet received with CRC good (pulse)
rec_data_pid1  in  1  with rec_data_ok: PID was DATA1
rec_data_bad  in  1  DATA packet received with CRC or PID error (pulse)

Behaviour:
- Reset: state IDLE; all outputs 0; toggle=0; all counters 0.
- States: IDLE, TOKEN, DATA_TX, WAIT_HS, WAIT_DATA, ACK_TX.
- IDLE + start: pulse send_token with token_in=dir_in in the same cycle; go to TOKEN; clear nak_cnt and to_cnt; latch dir.
- TOKEN, waiting for sent:
  - On sent with OUT: pulse send_data with data_pid1=toggle, go to DATA_TX.
  - On sent with IN: clear timer, go to WAIT_DATA.
- DATA_TX: on sent, clear timer and go to WAIT_HS.
- Timer:
  - Increments each cycle in WAIT_HS or WAIT_DATA.
  - rec_start clears it and holds it at 0 while high.
  - Timeout when timer == TIMEOUT_CYCLES-1.
- Event priority in a wait state, highest first: abort > response (rec_ACK, rec_NAK, rec_data_ok, rec_data_bad) > timeout.
- Response events that do not fit the direction are ignored: rec_data_* in WAIT_HS, rec_ACK/rec_NAK in WAIT_DATA.
- WAIT_HS (OUT):
  - rec_ACK: done+success, toggle flips, go to IDLE.
  - rec_NAK: nak_cnt+1.
  - timeout: to_cnt+1.
  - If the incremented count reaches its limit: done+failure with fail_code 1 or 2; no resend.
  - Otherwise pulse send_data (same toggle) and go to DATA_TX. The token is not resent.
- WAIT_DATA (IN):
  - rec_data_ok with rec_data_pid1==toggle: pulse send_ack, go to ACK_TX with flag good.
  - rec_data_ok with mismatched PID (duplicate): pulse send_ack, go to ACK_TX with flag dup.
  - rec_NAK: nak_cnt+1.
  - rec_data_bad or timeout: to_cnt+1; no ACK is sent.
  - Limit checks are the same as WAIT_HS. If no limit is hit, pulse send_token(IN) and go to TOKEN.
- ACK_TX: on sent:
  - good: done+success, toggle flips, go to IDLE.
  - dup: to_cnt+1, then the limit check. If the limit is reached, fail_code 2. Otherwise resend the IN token and go to TOKEN.
- abort in any non-IDLE state: done+failure, fail_code 3, go to IDLE next cycle; toggle unchanged. The sender may still finish the in-flight packet; that late sent is ignored in IDLE.
- done/success/failure/fail_code are combinational pulses in the cycle of the terminating event; busy falls the next cycle.
- start coincident with done (terminating cycle) is ignored; a new start is accepted in IDLE only.
- toggle_clr and start in the same IDLE cycle: the toggle is cleared and the token uses DATA0 semantics.
- Widths: timer $clog2(TIMEOUT_CYCLES); nak_cnt $clog2(MAX_NAK+1); to_cnt $clog2(MAX_TIMEOUT+1). Counters saturate and never wrap.
- Reset mid-transaction returns to IDLE immediately; no done pulse.

Test Plan:
- OUT, toggle=0, ACK after 10 cycles: send_token(token_in=0), send_data(pid1=0), then done+success; toggle becomes 1.
- OUT with 7 NAKs then ACK: send_data pulsed 8 times, success, no failure; with 8 NAKs: done+failure, fail_code=1 after the 8th NAK, no 9th send_data.
- IN with no response, TIMEOUT_CYCLES=16, MAX_TIMEOUT=3: IN token sent 3 times, each wait 16 cycles; failure with fail_code=2 at the 3rd expiry. rec_start at cycle 10 of a wait delays that expiry by 10+ cycles.
- IN with toggle=1, first reply DATA0 (dup): send_ack, IN token resent, toggle stays 1; next reply DATA1: send_ack, success, toggle=0.
- IN with rec_data_bad, then good data: no ACK for the bad packet, token resent, to_cnt=1, then success.
- abort during DATA_TX: done+failure, fail_code=3, toggle unchanged; late sent ignored. Next start runs normally.
